// File: rtl/bp_me_wormhole_out_arbiter_if.sv
// Flit bus between the input-channel adapters and one wormhole output link.
// slave: the arbiter's view. master: the side driving input flits and
// downstream ready.
interface bp_me_wormhole_out_arbiter_if #(
  parameter int num_in_p = 5,
  parameter int width_p  = 16
);
  logic [num_in_p*width_p-1:0] data_i;
  logic [num_in_p-1:0]         v_i;
  logic [num_in_p-1:0]         ready_o;
  logic [width_p-1:0]          data_o;
  logic                        v_o;
  logic                        ready_i;
  logic [num_in_p-1:0]         grant_o;
  logic                        busy_o;

  modport slave (
    input  data_i, v_i, ready_i,
    output ready_o, data_o, v_o, grant_o, busy_o
  );

  modport master (
    output data_i, v_i, ready_i,
    input  ready_o, data_o, v_o, grant_o, busy_o
  );
endinterface

// File: rtl/bp_me_wormhole_out_arbiter.sv
// Packet-granular round-robin allocator for one wormhole output link.
// The grant is taken on a header flit and held until the last body flit is
// accepted. The datapath is a pure mux, so flits pass with zero latency.
module bp_me_wormhole_out_arbiter #(
  parameter int num_in_p       = 5,
  parameter int width_p        = 16,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int len_width_p    = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bp_me_wormhole_out_arbiter_if.slave   bus
);
  localparam int PW   = $clog2(num_in_p);
  localparam int LOFF = x_cord_width_p + y_cord_width_p;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          owner;
  logic [len_width_p-1:0] cnt;

  logic [PW-1:0]          sel;
  logic                   sel_v;
  logic [num_in_p-1:0]    gnt;
  logic [width_p-1:0]     flit;
  logic                   xfer;

  // Pick the channel to mux: the packet owner while busy, otherwise the first
  // valid channel at or above rr_ptr, wrapping modulo num_in_p.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    idx   = 0;
    cand  = '0;
    sel   = '0;
    sel_v = 1'b0;
    if (state == BUSY) begin
      sel   = owner;
      sel_v = 1'b1;
    end else begin
      for (int i = 0; i < num_in_p; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= num_in_p) idx = idx - num_in_p;
        cand = PW'(idx);
        if (!sel_v && bus.v_i[cand]) begin
          sel   = cand;
          sel_v = 1'b1;
        end
      end
    end
  end

  // Outputs are forced quiet while reset is asserted, even mid-packet.
  assign gnt         = (sel_v && !reset_i) ? ({{(num_in_p-1){1'b0}}, 1'b1} << sel) : '0;
  assign flit        = bus.data_i[sel*width_p +: width_p];
  assign bus.data_o  = flit;
  assign bus.v_o     = (|gnt) & bus.v_i[sel];
  assign bus.grant_o = gnt;
  assign bus.ready_o = gnt & {num_in_p{bus.ready_i}};
  assign bus.busy_o  = (state == BUSY) & ~reset_i;
  assign xfer        = bus.v_o & bus.ready_i;

  // Packet FSM: the header transfer advances rr_ptr and, for multi-flit
  // packets, locks the owner until cnt body flits have been accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            rr_ptr <= (sel == PW'(num_in_p-1)) ? '0 : sel + 1'b1;
            if (flit[LOFF +: len_width_p] != '0) begin
              cnt   <= flit[LOFF +: len_width_p];
              owner <= sel;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (xfer) begin
            cnt <= cnt - 1'b1;
            if (cnt == len_width_p'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Grant stays one-hot or empty; no channel handshakes without v_o.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(bus.grant_o));
      assert (bus.v_o || ((bus.ready_o & bus.v_i) == '0));
    end
  end
`endif
endmodule

// File: tb/tb_bp_me_wormhole_out_arbiter.sv
// Bench for the wormhole output arbiter: per-channel packet sources, a
// behavioural arbitration model and a per-channel expected-flit scoreboard.
module tb_bp_me_wormhole_out_arbiter;
  localparam int NI = 5, W = 16, XW = 4, YW = 4, LW = 4, LOFF = XW + YW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_me_wormhole_out_arbiter_if #(.num_in_p(NI), .width_p(W)) bus();

  bp_me_wormhole_out_arbiter #(
    .num_in_p(NI), .width_p(W), .x_cord_width_p(XW),
    .y_cord_width_p(YW), .len_width_p(LW)
  ) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );

  int checks = 0, fails = 0;
  logic [W-1:0] src_q [NI][$];
  logic [W-1:0] exp_q [NI][$];
  int rem [NI];
  int wait_pk [NI];
  logic [NI-1:0] gap_ok;
  logic rdy;
  bit m_busy;
  int m_rr, m_owner, m_cnt;
  logic [NI-1:0] obs_grant, obs_ready;
  logic obs_v, obs_busy;
  int out_cnt;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Queue one packet: header with len field, then len random body flits.
  task automatic send_pkt(int ch, int len);
    logic [W-1:0] f;
    f = W'($urandom);
    f[LOFF +: LW] = LW'(len);
    src_q[ch].push_back(f);
    exp_q[ch].push_back(f);
    for (int k = 0; k < len; k++) begin
      f = W'($urandom);
      src_q[ch].push_back(f);
      exp_q[ch].push_back(f);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int j = 0; j < NI; j++) n += src_q[j].size();
    return n;
  endfunction

  // One clock: drive at negedge, check mid-cycle, update model after posedge.
  task automatic cycle();
    logic [NI-1:0] v, eg, erdy;
    logic [NI*W-1:0] d;
    logic [W-1:0] f;
    logic ev, xfer;
    int ech, idx;
    v = '0; d = '0;
    for (int j = 0; j < NI; j++) begin
      if (src_q[j].size() > 0) begin
        d[j*W +: W] = src_q[j][0];
        if (rem[j] == 0 || gap_ok[j]) v[j] = 1'b1;
      end
    end
    bus.v_i = v; bus.data_i = d; bus.ready_i = rdy;
    ech = -1;
    if (!rst) begin
      if (m_busy) ech = m_owner;
      else for (int i = 0; i < NI; i++) begin
        idx = (m_rr + i) % NI;
        if (ech < 0 && v[idx]) ech = idx;
      end
    end
    eg = '0; ev = 1'b0;
    if (ech >= 0) begin
      eg = NI'(1) << ech;
      ev = v[ech];
    end
    erdy = rdy ? eg : '0;
    xfer = ev && rdy;
    #2;
    obs_grant = bus.grant_o; obs_ready = bus.ready_o;
    obs_v = bus.v_o; obs_busy = bus.busy_o;
    chk("grant", obs_grant, eg);
    chk("v_o", obs_v, ev);
    chk("ready_o", obs_ready, erdy);
    chk("busy_o", obs_busy, !rst && m_busy);
    if (bus.v_o && rdy) out_cnt++;
    if (xfer) begin
      chk("data_o", bus.data_o, exp_q[ech][0]);
      if (!m_busy) begin
        chk("fair", wait_pk[ech] < NI, 1);
        wait_pk[ech] = 0;
        for (int j = 0; j < NI; j++)
          if (j != ech && v[j] && rem[j] == 0) wait_pk[j]++;
      end
    end
    @(posedge clk); #1;
    if (rst) begin
      m_busy = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
      for (int j = 0; j < NI; j++) begin
        src_q[j].delete(); exp_q[j].delete(); rem[j] = 0; wait_pk[j] = 0;
      end
    end else if (xfer) begin
      f = src_q[ech].pop_front();
      void'(exp_q[ech].pop_front());
      if (!m_busy) begin
        m_rr = (ech + 1) % NI;
        rem[ech] = int'(f[LOFF +: LW]);
        if (rem[ech] != 0) begin
          m_busy = 1; m_cnt = rem[ech]; m_owner = ech;
        end
      end else begin
        m_cnt--; rem[ech]--;
        if (m_cnt == 0) m_busy = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic drain(int bound);
    int n = 0;
    rdy = 1'b1; gap_ok = '1;
    while (pending() > 0 && n < bound) begin
      cycle(); n++;
    end
    chk("drain_left", pending(), 0);
    chk("drain_idle", m_busy, 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; gap_ok = '1; out_cnt = 0;
    m_busy = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
    for (int j = 0; j < NI; j++) begin rem[j] = 0; wait_pk[j] = 0; end
    bus.v_i = '0; bus.data_i = '0; bus.ready_i = 1'b1;
    @(negedge clk);
    do_reset();

    // Single packet from ch2, len=3.
    send_pkt(2, 3);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t1_v", obs_v, 1);
      chk("t1_busy", obs_busy, k != 0);
      chk("t1_grant", obs_grant, NI'(4));
    end
    cycle();
    chk("t1_idle_v", obs_v, 0);
    chk("t1_idle_busy", obs_busy, 0);
    for (int j = 0; j < NI; j++) send_pkt(j, 0);
    cycle();
    chk("t1_rr3", obs_grant, NI'(8));
    drain(100);

    // Round robin with continuous len=0 headers.
    do_reset();
    for (int r = 0; r < 2; r++) for (int j = 0; j < NI; j++) send_pkt(j, 0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t2_order", obs_grant, NI'(1) << (k % NI));
    end
    drain(100);

    // Lock: ch1 must wait for ch0's whole packet.
    do_reset();
    send_pkt(0, 2); send_pkt(1, 0);
    cycle();
    chk("t3_hdr0", obs_grant, 1);
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("t3_lock", obs_ready[1], 0);
      chk("t3_own", obs_grant, 1);
    end
    cycle();
    chk("t3_ch1", obs_grant, 2);
    chk("t3_v1", obs_v, 1);
    drain(100);

    // Backpressure and owner gaps inside a len=4 packet.
    do_reset();
    out_cnt = 0;
    send_pkt(0, 4);
    for (int k = 0; k < 24; k++) begin
      rdy = (k % 2 == 0);
      gap_ok = (k % 3 == 1) ? '0 : '1;
      cycle();
    end
    chk("t4_count", out_cnt, 5);
    chk("t4_empty", src_q[0].size(), 0);
    drain(100);

    // Reset in the middle of a len=5 packet.
    do_reset();
    send_pkt(0, 5);
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("t5_rst_v", obs_v, 0);
    chk("t5_rst_grant", obs_grant, 0);
    rst = 1'b0;
    cycle();
    chk("t5_v", obs_v, 0);
    chk("t5_busy", obs_busy, 0);
    send_pkt(4, 0); send_pkt(0, 0); send_pkt(2, 0);
    cycle();
    chk("t5_ch0", obs_grant, 1);
    drain(100);

    // Random traffic against the model and scoreboard.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int j = 0; j < NI; j++)
        if (src_q[j].size() == 0 && $urandom_range(3) == 0)
          send_pkt(j, ($urandom_range(7) == 0) ? 15 : int'($urandom_range(3)));
      rdy = ($urandom_range(3) != 0);
      gap_ok = NI'($urandom);
      cycle();
    end
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
